ir_fetch_unit: RTL

- Instruction fetch stage sitting directly upstream of the instruction register file.
- Walks a program counter through instruction memory using a single-outstanding req/ack handshake.
- Buffers returned words with their PC in a small prefetch FIFO and presents them to the IR regfile write port through valid/ready.
- Supports redirect (branch) with flush, and a boot sequence started by i_start.

---
 rtl/ir_fetch_pkg.sv | 20 ++
 rtl/ir_fetch_fifo.sv | 59 +++++
 rtl/ir_fetch_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ir_fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
// Used by ir_fetch_fifo and ir_fetch_unit.
package ir_fetch_pkg;

   localparam int GLOBAL_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH    = 8;
   localparam int DEF_ENTRY_WIDTH   = DEF_ADDR_WIDTH + GLOBAL_DATA_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   function automatic int entry_width(input int aw, input int dw);
      return aw + dw;
   endfunction

endpackage

// File: rtl/ir_fetch_fifo.sv
// First-word-fall-through prefetch FIFO holding {pc, instruction} entries.
// Flush wins over push and pop.
module ir_fetch_fifo
   import ir_fetch_pkg::*;
#(
   parameter int WIDTH = DEF_ENTRY_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ir_fetch_unit.sv
// Instruction fetch stage: single-outstanding memory fetch into a prefetch FIFO.
// Define IR_FETCH_TIMEOUT_EN to add the ack timeout and sticky o_fetch_err.
module ir_fetch_unit
   import ir_fetch_pkg::*;
#(
   parameter int DATA_WIDTH = GLOBAL_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = 4,
`ifdef IR_FETCH_TIMEOUT_EN
   parameter int TIMEOUT    = 15,
`endif
   parameter int BOOT_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic                  i_branch_en,
   input  logic [ADDR_WIDTH-1:0] i_branch_addr,
   output logic                  o_mem_req,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   input  logic                  i_mem_ack,
   input  logic [DATA_WIDTH-1:0] i_mem_data,
   output logic                  o_ir_valid,
   output logic [DATA_WIDTH-1:0] o_ir_data,
   output logic [ADDR_WIDTH-1:0] o_ir_pc,
   input  logic                  i_ir_ready,
   output logic                  o_busy
`ifdef IR_FETCH_TIMEOUT_EN
   ,
   output logic                  o_fetch_err
`endif
);

   localparam int EW = entry_width(ADDR_WIDTH, DATA_WIDTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] BOOT_PC = ADDR_WIDTH'(BOOT_ADDR);

   state_t                state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [EW-1:0]         head;
   logic [CW-1:0]         count;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  flush;
   logic                  credit;
   logic                  redirect;
   logic                  tmo;

   assign redirect = i_branch_en && (state != S_IDLE);
   assign push     = (state == S_WAIT) && i_mem_ack && !i_branch_en;
   assign pop      = o_ir_valid && i_ir_ready;
   assign flush    = redirect || tmo;
   // Reserve a slot for every request in flight so an ack can always land.
   assign credit   = !full &&
                     ((32'(count) + 32'(o_mem_req)) < DEPTH);

   assign o_busy     = (state != S_IDLE);
   assign o_ir_valid = !empty;
   assign o_ir_pc    = empty ? '0 : head[EW-1 -: ADDR_WIDTH];
   assign o_ir_data  = empty ? '0 : head[DATA_WIDTH-1:0];

   ir_fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata ({pc, i_mem_data}),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

`ifdef IR_FETCH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] tcnt;
   logic          waiting;

   assign waiting = (state == S_WAIT) || (state == S_DRAIN);
   assign tmo     = waiting && !i_mem_ack &&
                    (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tcnt        <= '0;
         o_fetch_err <= 1'b0;
      end else begin
         if (!waiting || i_mem_ack)
            tcnt <= '0;
         else
            tcnt <= tcnt + 1'b1;
         if (tmo)
            o_fetch_err <= 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pc         <= BOOT_PC;
         o_mem_req  <= 1'b0;
         o_mem_addr <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (i_start) begin
                  pc    <= BOOT_PC;
                  state <= S_REQ;
               end
            end
            S_REQ: begin
               if (i_branch_en) begin
                  pc <= i_branch_addr;
               end else if (credit) begin
                  o_mem_req  <= 1'b1;
                  o_mem_addr <= pc;
                  state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_branch_en) begin
                  pc <= i_branch_addr;
                  if (i_mem_ack) begin
                     o_mem_req <= 1'b0;
                     state     <= S_REQ;
                  end else begin
                     state <= S_DRAIN;
                  end
               end else if (i_mem_ack) begin
                  pc        <= pc + 1'b1;
                  o_mem_req <= 1'b0;
                  state     <= S_REQ;
               end
            end
            S_DRAIN: begin
               // The stale request must still complete before a new one issues.
               if (i_branch_en)
                  pc <= i_branch_addr;
               if (i_mem_ack) begin
                  o_mem_req <= 1'b0;
                  state     <= S_REQ;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
         if (tmo) begin
            o_mem_req <= 1'b0;
            state     <= S_IDLE;
         end
      end
   end

endmodule
